// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : core_pkg
// Purpose  : Shared types and constants for the pipeline control logic:
//            hazard FSM states, the x0 register index and the
//            forward-select encodings.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_perf_cnt
// Purpose  : Free-running wrap-around event counter with an increment input.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: add one when the event fires, wrapping naturally past all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_ctrl
// Purpose  : Stall/flush controller for the five-stage core. Resolves
//            load-use, taken-branch redirect, I-cache miss and D-cache miss
//            hazards and counts stall cycles and load-use bubbles.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic [4:0]       rdE,
  input  logic             memreadE,
  input  logic             redirectE,
  input  logic             icache_reqF,
  input  logic             icache_readyF,
  input  logic             dcache_reqM,
  input  logic             dcache_readyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] loaduse_events
);

  hazard_state_t state_q;
  hazard_state_t state_d;
  logic          pending_q;
  logic          pending_d;

  logic w_dmiss;
  logic w_imiss;
  logic w_redirect;
  logic w_loaduse;
  logic w_pend_set;
  logic w_pend_kill;

  // Hazard detection, in priority order: D-miss freezes everything, a
  // redirect squashes the ID instruction so a load-use on it is moot.
  always_comb begin
    w_dmiss    = dcache_reqM && !dcache_readyM;
    w_imiss    = icache_reqF && !icache_readyF && !w_dmiss;
    w_redirect = redirectE && !w_dmiss;
    w_loaduse  = memreadE && (rdE != REG_ZERO) &&
                 ((use_rs1D && (rdE == rs1D)) || (use_rs2D && (rdE == rs2D))) &&
                 !w_dmiss && !redirectE;
    // A redirect seen while fetch is waiting (or in the refill cycle) means
    // the returning line is wrong-path and must be killed when it lands.
    w_pend_set  = w_redirect && (w_imiss || (state_q == IMISS));
    w_pend_kill = pending_q && icache_readyF && !w_dmiss;
  end

  // Stall/flush outputs, combinational for zero-cycle decision latency.
  always_comb begin
    stallF = w_dmiss || w_imiss || w_loaduse;
    stallD = w_dmiss || w_loaduse;
    stallE = w_dmiss;
    stallM = w_dmiss;
    flushW = w_dmiss;
    flushD = w_redirect || w_imiss || w_pend_kill;
    flushE = w_redirect || w_loaduse;
  end

  // Next state and next pending-redirect flag.
  always_comb begin
    state_d = RUN;
    if (w_dmiss) begin
      state_d = DMISS;
    end else if (w_imiss) begin
      state_d = IMISS;
    end
    pending_d = w_pend_set || (pending_q && !w_pend_kill);
  end

  // FSM state and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stallF),
    .cnt_o (stall_cycles)
  );

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_loaduse_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_loaduse),
    .cnt_o (loaduse_events)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl: a vector table for
//            single-cycle decisions plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [4:0]    rs1D, rs2D, rdE;
  logic          use_rs1D, use_rs2D, memreadE, redirectE;
  logic          icache_reqF, icache_readyF, dcache_reqM, dcache_readyM;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [CW-1:0] stall_cycles, loaduse_events;

  int n_checks;
  int n_errors;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1D           (rs1D),
    .rs2D           (rs2D),
    .use_rs1D       (use_rs1D),
    .use_rs2D       (use_rs2D),
    .rdE            (rdE),
    .memreadE       (memreadE),
    .redirectE      (redirectE),
    .icache_reqF    (icache_reqF),
    .icache_readyF  (icache_readyF),
    .dcache_reqM    (dcache_reqM),
    .dcache_readyM  (dcache_readyM),
    .stallF         (stallF),
    .stallD         (stallD),
    .stallE         (stallE),
    .stallM         (stallM),
    .flushD         (flushD),
    .flushE         (flushE),
    .flushW         (flushW),
    .stall_cycles   (stall_cycles),
    .loaduse_events (loaduse_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ur1;
    logic       ur2;
    logic [4:0] rd;
    logic       mem;
    logic       redir;
    logic       ireq;
    logic       irdy;
    logic       dreq;
    logic       drdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic ur1, logic ur2,
                              logic [4:0] rd, logic mem, logic redir, logic ireq,
                              logic irdy, logic dreq, logic drdy, logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.ur1 = ur1; v.ur2 = ur2; v.rd = rd; v.mem = mem;
    v.redir = redir; v.ireq = ireq; v.irdy = irdy; v.dreq = dreq; v.drdy = drdy;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
  endfunction

  task automatic check_out(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs {sF,sD,sE,sM,fD,fE,fW} got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] act,
                           input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: counter got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1D = 5'd0; rs2D = 5'd0; use_rs1D = 1'b0; use_rs2D = 1'b0;
    rdE = 5'd0; memreadE = 1'b0; redirectE = 1'b0;
    icache_reqF = 1'b0; icache_readyF = 1'b0;
    dcache_reqM = 1'b0; dcache_readyM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_out("reset_outs", 7'b0);
    check_cnt("reset_stall_cnt", stall_cycles, '0);
    check_cnt("reset_lu_cnt", loaduse_events, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to the next falling edge; caller drives inputs, then settle().
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();

    vecs[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    vecs[1]  = mk(5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, 0, 0, 7'b1100010);
    vecs[2]  = mk(5'd1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0, 0, 0, 7'b0000000);
    vecs[3]  = mk(5'd7, 5'd2, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 7'b0000000);
    vecs[4]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 0, 7'b0000110);
    vecs[5]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 7'b1000100);
    vecs[6]  = mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 1, 0, 0, 0, 7'b1100110);
    vecs[7]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0, 7'b1111001);
    vecs[8]  = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0, 1, 0, 7'b1111001);
    vecs[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1, 7'b0000000);
    vecs[10] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, 7'b0000000);
    vecs[11] = mk(5'd4, 5'd4, 1, 1, 5'd4, 1, 0, 0, 0, 0, 0, 7'b1100010);

    do_reset();

    // ---- single-cycle decision table ----
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      rs1D = vecs[i].rs1; rs2D = vecs[i].rs2;
      use_rs1D = vecs[i].ur1; use_rs2D = vecs[i].ur2;
      rdE = vecs[i].rd; memreadE = vecs[i].mem; redirectE = vecs[i].redir;
      icache_reqF = vecs[i].ireq; icache_readyF = vecs[i].irdy;
      dcache_reqM = vecs[i].dreq; dcache_readyM = vecs[i].drdy;
      settle();
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- load-use on rs1: one bubble, then clear ----
    do_reset();
    next_cycle();
    memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; use_rs1D = 1'b1;
    settle();
    check_out("lu_bubble", 7'b1100010);
    next_cycle();
    clear_inputs();
    settle();
    check_out("lu_after", 7'b0);
    check_cnt("lu_events", loaduse_events, 4'd1);
    check_cnt("lu_stall_cnt", stall_cycles, 4'd1);

    // ---- same load with rdE = x0: no hazard ----
    do_reset();
    next_cycle();
    memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; use_rs1D = 1'b1;
    settle();
    check_out("lu_x0", 7'b0);
    next_cycle();
    clear_inputs();
    settle();
    check_cnt("lu_x0_events", loaduse_events, 4'd0);

    // ---- 4-cycle D-miss with a redirect held during the miss ----
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      dcache_reqM = 1'b1; dcache_readyM = 1'b0;
      redirectE = (c >= 1);
      settle();
      check_out($sformatf("dmiss_c%0d", c), 7'b1111001);
    end
    next_cycle();
    dcache_readyM = 1'b1;
    settle();
    check_out("dmiss_release", 7'b0000110);
    check_cnt("dmiss_stall_cnt", stall_cycles, 4'd4);
    next_cycle();
    clear_inputs();
    settle();
    check_out("dmiss_idle", 7'b0);
    check_cnt("dmiss_stall_cnt2", stall_cycles, 4'd4);

    // ---- 3-cycle I-miss with redirect in its 2nd cycle ----
    do_reset();
    next_cycle();
    icache_reqF = 1'b1; icache_readyF = 1'b0;
    settle();
    check_out("imiss_c0", 7'b1000100);
    next_cycle();
    redirectE = 1'b1;
    settle();
    check_out("imiss_c1_redir", 7'b1000110);
    next_cycle();
    redirectE = 1'b0;
    settle();
    check_out("imiss_c2", 7'b1000100);
    next_cycle();
    icache_readyF = 1'b1;
    settle();
    check_out("imiss_ready_kill", 7'b0000100);
    next_cycle();
    settle();
    check_out("imiss_pending_clr", 7'b0);
    check_cnt("imiss_stall_cnt", stall_cycles, 4'd3);

    // ---- second redirect in the refill cycle keeps pending set ----
    do_reset();
    next_cycle();
    icache_reqF = 1'b1; icache_readyF = 1'b0; redirectE = 1'b1;
    settle();
    check_out("pend2_c0", 7'b1000110);
    next_cycle();
    icache_readyF = 1'b1;
    settle();
    check_out("pend2_ready_redir", 7'b0000110);
    next_cycle();
    redirectE = 1'b0;
    settle();
    check_out("pend2_kill", 7'b0000100);
    next_cycle();
    settle();
    check_out("pend2_clr", 7'b0);

    // ---- redirect together with a load-use hazard ----
    do_reset();
    next_cycle();
    memreadE = 1'b1; rdE = 5'd6; rs2D = 5'd6; use_rs2D = 1'b1; redirectE = 1'b1;
    settle();
    check_out("redir_lu", 7'b0000110);
    next_cycle();
    clear_inputs();
    settle();
    check_cnt("redir_lu_events", loaduse_events, 4'd0);

    // ---- D-miss overlapping I-miss, I-miss outlives it ----
    do_reset();
    next_cycle();
    icache_reqF = 1'b1; dcache_reqM = 1'b1;
    settle();
    check_out("both_miss", 7'b1111001);
    next_cycle();
    dcache_reqM = 1'b0;
    settle();
    check_out("imiss_after_dmiss", 7'b1000100);

    // ---- reset in the 2nd cycle of a D-miss ----
    do_reset();
    next_cycle();
    dcache_reqM = 1'b1;
    settle();
    next_cycle();
    settle();
    check_out("rst_dmiss_c1", 7'b1111001);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_out("rst_mid_outs", 7'b0);
    check_cnt("rst_mid_stall_cnt", stall_cycles, 4'd0);
    check_cnt("rst_mid_lu_cnt", loaduse_events, 4'd0);
    next_cycle();
    rst_n = 1'b1;
    settle();
    check_out("rst_release_run", 7'b0);

    // ---- reset drops a pending redirect ----
    do_reset();
    next_cycle();
    icache_reqF = 1'b1; redirectE = 1'b1;
    settle();
    check_out("rst_pend_set", 7'b1000110);
    next_cycle();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    icache_reqF = 1'b1; icache_readyF = 1'b1;
    settle();
    check_out("rst_pend_dropped", 7'b0);

    // ---- stall counter wraps past all-ones ----
    do_reset();
    for (int c = 0; c < 17; c++) begin
      next_cycle();
      icache_reqF = 1'b1; icache_readyF = 1'b0;
    end
    next_cycle();
    clear_inputs();
    settle();
    check_cnt("stall_cnt_wrap", stall_cycles, 4'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core with instruction and data caches. It sits beside the ID/EX/MEM stages and runs alongside the EX-stage forwarding unit. It covers every hazard that forwarding cannot resolve: load-use, taken-branch redirect, I-cache miss and D-cache miss. It drives per-stage stall and flush controls into the pipeline registers and keeps stall performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1D, rs2D  in  5 each  source registers of the instruction in ID
- use_rs1D, use_rs2D  in  1 each  the ID instruction actually reads rs1 / rs2
- rdE  in  5  destination register of the instruction in EX
- memreadE  in  1  the EX instruction is a load
- redirectE  in  1  taken branch or jump resolved in EX
- icache_reqF  in  1  fetch access active
- icache_readyF  in  1  I-cache data valid this cycle
- dcache_reqM  in  1  load/store access active in MEM
- dcache_readyM  in  1  D-cache access completes this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register
- flushD, flushE, flushW  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB
- stall_cycles  out  CNT_W  count of cycles with stallF=1
- loaduse_events  out  CNT_W  count of load-use bubbles inserted

## Operation
- FSM states: RUN, IMISS, DMISS. The state register is clocked and reset to RUN.
- D-miss has the highest priority.
  - Condition: dcache_reqM && !dcache_readyM.
  - Response: stallF=stallD=stallE=stallM=1 and flushW=1, combinationally in the same cycle.
  - State goes to DMISS and stays there while the condition holds.
  - On dcache_readyM=1, outputs release in that cycle and the next state is RUN.
  - redirectE and load-use are ignored during a D-miss. E is held, so they re-present afterwards.
- Redirect: redirectE=1 with no D-miss forces flushD=1 and flushE=1. Load-use is suppressed in the same cycle.
- Load-use:
  - Condition: memreadE && rdE!=0 && ((use_rs1D && rdE==rs1D) || (use_rs2D && rdE==rs2D)), with no D-miss and no redirect.
  - Response: stallF=stallD=1 and flushE=1 for exactly one cycle; loaduse_events increments.
- I-miss:
  - Condition: icache_reqF && !icache_readyF, with no D-miss.
  - Response: stallF=1 and flushD=1, so downstream stages keep draining. State goes to IMISS.
  - Exit: on icache_readyF=1, next state is RUN.
- Redirect during IMISS: flushD/flushE apply as usual, and the redirect_pending register is set.
  - In the cycle icache_readyF=1 while pending is set, flushD=1 kills the wrong-path fetch and pending clears.
  - A further redirect in that same cycle keeps pending set.
- Load-use during IMISS: stallD=1 and flushE=1 as usual. stallF is already 1.
- Counters are free-running and wrap to 0 past 2^CNT_W−1. They update on clk, with no enable.
- Both counters increment together when a load-use occurs alongside a stall.

## Timing
- All stall/flush outputs are combinational from the current state, redirect_pending and the inputs. The decision latency is 0 cycles.
- State, redirect_pending and counters update on the rising edge of clk.
- Reset (asynchronous, rst_n=0):
  - State is RUN, redirect_pending=0, stall_cycles=0, loaduse_events=0.
  - With all inputs 0, every output is 0.
- Reset mid-miss returns to RUN immediately and drops any pending redirect.
- Simultaneous I-miss and D-miss: DMISS takes precedence. An I-miss still outstanding afterwards moves to IMISS on the next evaluation.
- dcache_readyM=1 in the first cycle of a request means no stall and no state change.

## Structure
- Shared package core_pkg:
  - hazard_state_t enum (RUN, IMISS, DMISS).
  - REG_ZERO constant.
  - Forward-select encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, for common use with the forwarding unit.
- One sub-module, hazard_perf_cnt: a CNT_W wrap-around counter with async active-low reset and an inc input, instantiated twice.

## Test plan
- Load in EX, rdE=5, memreadE=1, ID rs1D=5 with use_rs1D=1 -> one cycle of stallF=stallD=flushE=1, then all 0; loaduse_events=1.
- Same as above but rdE=0 -> no stall; loaduse_events stays 0.
- dcache_reqM=1 with readyM low for 4 cycles -> stallF/D/E/M and flushW=1 for exactly 4 cycles; stall_cycles=4. A redirectE presented in that window produces no flush until after release.
- I-miss of 3 cycles with redirectE=1 in its 2nd cycle -> flushD/flushE in that cycle, then flushD=1 again in the readyF cycle; pending clears.
- redirectE and a load-use hazard in the same cycle -> flushD=flushE=1, stallF=stallD=0, loaduse_events unchanged.
- rst_n pulled low in the 2nd cycle of DMISS -> all outputs and counters 0 immediately; FSM is in RUN on release.
